instruction_fetch_controller: RTL

//  Upstream neighbour of instruction_decode_controller. Walks PC from 0 to last_pc and reads each
//  59-bit instruction from a synchronous instruction memory. Stamps the current PC into bits [36:32]
//  and hands the word to the decode controller via a start/busy/done handshake. Issues exactly one

---
 rtl/instruction_fetch_controller.sv | 105 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_controller.sv
// Fetches instructions PC 0..last_pc from a synchronous memory, stamps the PC
// into the word and hands it to the decode controller one at a time.
module instruction_fetch_controller #(
    parameter int INSTR_W = 59,
    parameter int PC_W    = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [PC_W-1:0]    last_pc,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               start,
    input  logic               dec_busy,
    input  logic               dec_done,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_count
);

    // state    | meaning
    // IDLE     | waiting for run
    // READ     | memory read strobe at pc
    // CAPTURE  | latch read data with pc stamped in
    // DISPATCH | start held until decode reports busy
    // WAIT     | waiting for done with busy low
    // HALT     | program finished, left only by reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_DISPATCH,
        S_WAIT,
        S_HALT
    } state_t;

    state_t state, state_nxt;
    logic   retire;
    logic   unused_pc_field;

    // The memory word's own PC field is replaced, so those bits are never consumed.
    assign unused_pc_field = ^imem_rdata[32+PC_W-1:32];
    assign imem_addr       = pc;

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        imem_rd_en = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (run) state_nxt = S_READ;
            end
            S_READ: begin
                imem_rd_en = 1'b1;
                state_nxt  = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_nxt = S_DISPATCH;
            end
            S_DISPATCH: begin
                start = 1'b1;
                if (dec_busy) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (dec_done && !dec_busy) begin
                    retire = 1'b1;
                    if (pc == last_pc) state_nxt = S_HALT;
                    else if (run)      state_nxt = S_READ;
                    else               state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            instruction <= '0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CAPTURE) begin
                instruction <= {imem_rdata[INSTR_W-1:32+PC_W], pc, imem_rdata[31:0]};
            end
            if (retire) begin
                if (instr_count != '1) instr_count <= instr_count + CNT_W'(1);
                if (pc == last_pc) halted <= 1'b1;
                else               pc     <= pc + PC_W'(1);
            end
        end
    end

endmodule
